// File: rtl/traffic_intersection.sv
// Two-approach traffic controller: NS/EW greens with all-red clearance,
// demand-shortened greens, pedestrian walk phase and night flashing.
module traffic_intersection #(
    parameter int TIMER_W   = 8,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 10,
    parameter int YELLOW_T  = 2,
    parameter int RED_CLR   = 1,
    parameter int WALK_T    = 3,
    parameter int FLASH_T   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ns_req,
    input  logic       ew_req,
    input  logic       ped_req,
    input  logic       flash_en,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        CLR_EW    = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        CLR_NS    = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        WALK      = 3'd6,
        FLASH     = 3'd7
    } state_t;

    // Last-cycle timer values: a state of duration N exits at timer N-1.
    localparam logic [TIMER_W-1:0] T_GMIN  = TIMER_W'(GREEN_MIN - 1);
    localparam logic [TIMER_W-1:0] T_GMAX  = TIMER_W'(GREEN_MAX - 1);
    localparam logic [TIMER_W-1:0] T_YEL   = TIMER_W'(YELLOW_T - 1);
    localparam logic [TIMER_W-1:0] T_CLR   = TIMER_W'(RED_CLR - 1);
    localparam logic [TIMER_W-1:0] T_WALK  = TIMER_W'(WALK_T - 1);
    localparam logic [TIMER_W-1:0] T_FLASH = TIMER_W'(FLASH_T - 1);

    state_t             state, state_nxt;
    logic [TIMER_W-1:0] timer, timer_nxt;
    logic               ped_pend, ped_nxt;
    logic               flash_ph, flash_nxt;
    logic               from_ns, from_ns_nxt;
    logic               wrap;

    assign phase = state;

    always_comb begin
        state_nxt   = state;
        flash_nxt   = flash_ph;
        from_ns_nxt = from_ns;
        wrap        = 1'b0;
        unique case (state)
            NS_GREEN: begin
                if (timer == T_GMAX ||
                    (timer >= T_GMIN && (ew_req || ped_pend || flash_en)))
                    state_nxt = NS_YELLOW;
            end
            NS_YELLOW: if (timer == T_YEL) state_nxt = CLR_NS;
            EW_GREEN: begin
                if (timer == T_GMAX ||
                    (timer >= T_GMIN && (ns_req || ped_pend || flash_en)))
                    state_nxt = EW_YELLOW;
            end
            EW_YELLOW: if (timer == T_YEL) state_nxt = CLR_EW;
            CLR_NS, CLR_EW: begin
                if (timer == T_CLR) begin
                    if (flash_en) begin
                        state_nxt = FLASH;
                    end else if (ped_pend) begin
                        state_nxt   = WALK;
                        from_ns_nxt = (state == CLR_NS);
                    end else begin
                        state_nxt = (state == CLR_NS) ? EW_GREEN : NS_GREEN;
                    end
                end
            end
            WALK: begin
                if (timer == T_WALK)
                    state_nxt = from_ns ? EW_GREEN : NS_GREEN;
            end
            FLASH: begin
                if (!flash_en) begin
                    state_nxt = CLR_EW;
                end else if (timer == T_FLASH) begin
                    flash_nxt = ~flash_ph;
                    wrap      = 1'b1;
                end
            end
            default: state_nxt = CLR_EW;
        endcase

        if (state_nxt == FLASH && state != FLASH)
            flash_nxt = 1'b1;

        timer_nxt = (state_nxt != state || wrap) ? '0 : timer + 1'b1;

        // A pending request is dropped when it is served or when night mode ends.
        ped_nxt = ped_pend || (ped_req && state != WALK);
        if ((state_nxt == WALK && state != WALK) ||
            (state == FLASH && state_nxt != FLASH))
            ped_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= CLR_EW;
            timer     <= '0;
            ped_pend  <= 1'b0;
            flash_ph  <= 1'b0;
            from_ns   <= 1'b0;
            ns_red    <= 1'b1;
            ns_yellow <= 1'b0;
            ns_green  <= 1'b0;
            ew_red    <= 1'b1;
            ew_yellow <= 1'b0;
            ew_green  <= 1'b0;
            walk      <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            ped_pend  <= ped_nxt;
            flash_ph  <= flash_nxt;
            from_ns   <= from_ns_nxt;
            ns_red    <= 1'b1;
            ns_yellow <= 1'b0;
            ns_green  <= 1'b0;
            ew_red    <= 1'b1;
            ew_yellow <= 1'b0;
            ew_green  <= 1'b0;
            walk      <= 1'b0;
            unique case (state_nxt)
                NS_GREEN: begin
                    ns_red   <= 1'b0;
                    ns_green <= 1'b1;
                end
                NS_YELLOW: begin
                    ns_red    <= 1'b0;
                    ns_yellow <= 1'b1;
                end
                EW_GREEN: begin
                    ew_red   <= 1'b0;
                    ew_green <= 1'b1;
                end
                EW_YELLOW: begin
                    ew_red    <= 1'b0;
                    ew_yellow <= 1'b1;
                end
                WALK: walk <= 1'b1;
                FLASH: begin
                    ns_red    <= 1'b0;
                    ns_yellow <= flash_nxt;
                    ew_red    <= flash_nxt;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_intersection.sv
// Directed bench: default-timed controller plus a short-timer variant,
// checked cycle by cycle against hand-written phase/lamp sequences.
module tb_traffic_intersection;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rst2 = 1'b0;
    logic       ns_req = 1'b0;
    logic       ew_req = 1'b0;
    logic       ped_req = 1'b0;
    logic       flash_en = 1'b0;

    logic       ns_red, ns_yellow, ns_green;
    logic       ew_red, ew_yellow, ew_green, walk;
    logic [2:0] phase;
    logic       ns_red2, ns_yellow2, ns_green2;
    logic       ew_red2, ew_yellow2, ew_green2, walk2;
    logic [2:0] phase2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    traffic_intersection dut (
        .clk(clk), .rst(rst),
        .ns_req(ns_req), .ew_req(ew_req),
        .ped_req(ped_req), .flash_en(flash_en),
        .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
        .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
        .walk(walk), .phase(phase)
    );

    traffic_intersection #(
        .TIMER_W(4), .GREEN_MIN(1), .GREEN_MAX(15),
        .YELLOW_T(1), .RED_CLR(3)
    ) dut2 (
        .clk(clk), .rst(rst2),
        .ns_req(ns_req), .ew_req(ew_req),
        .ped_req(ped_req), .flash_en(flash_en),
        .ns_red(ns_red2), .ns_yellow(ns_yellow2), .ns_green(ns_green2),
        .ew_red(ew_red2), .ew_yellow(ew_yellow2), .ew_green(ew_green2),
        .walk(walk2), .phase(phase2)
    );

    wire [6:0] lamps1 = {ns_red, ns_yellow, ns_green,
                         ew_red, ew_yellow, ew_green, walk};
    wire [6:0] lamps2 = {ns_red2, ns_yellow2, ns_green2,
                         ew_red2, ew_yellow2, ew_green2, walk2};

    task automatic chk(input string tag, input int unsigned obs,
                       input int unsigned exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // {ns r,y,g, ew r,y,g, walk} for each non-flash phase
    function automatic logic [6:0] exp_lamps(input logic [2:0] p);
        case (p)
            3'd1:    return 7'b001_100_0;
            3'd2:    return 7'b010_100_0;
            3'd4:    return 7'b100_001_0;
            3'd5:    return 7'b100_010_0;
            3'd6:    return 7'b100_100_1;
            default: return 7'b100_100_0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ph(input int sel, input logic [2:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel == 0) begin
                chk("phase", phase, p);
                chk("lamps", lamps1, exp_lamps(p));
                chk("safe", (ns_yellow | ns_green) & (ew_yellow | ew_green), 0);
            end else begin
                chk("phase2", phase2, p);
                chk("lamps2", lamps2, exp_lamps(p));
            end
            step();
        end
    endtask

    task automatic expect_flash(input logic f);
        chk("phase_fl", phase, 7);
        chk("lamps_fl", lamps1, {1'b0, f, 1'b0, f, 3'b000});
        step();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        chk("rst_phase", phase, 0);
        chk("rst_lamps", lamps1, 7'b100_100_0);
        rst = 1'b1;
    endtask

    task automatic full_period();
        expect_ph(0, 0, 1);
        expect_ph(0, 1, 10);
        expect_ph(0, 2, 2);
        expect_ph(0, 3, 1);
        expect_ph(0, 4, 10);
        expect_ph(0, 5, 2);
        expect_ph(0, 0, 1);
        expect_ph(0, 1, 10);
    endtask

    initial begin
        // fixed timing with no demand
        do_reset();
        full_period();

        // EW demand shortens NS green to the minimum
        ew_req = 1'b1;
        do_reset();
        expect_ph(0, 0, 1);
        expect_ph(0, 1, 4);
        expect_ph(0, 2, 2);
        expect_ph(0, 3, 1);
        expect_ph(0, 4, 10);
        ew_req = 1'b0;

        // pedestrian pulse, and a second pulse during WALK ignored
        do_reset();
        expect_ph(0, 0, 1);
        expect_ph(0, 1, 1);
        ped_req = 1'b1;
        expect_ph(0, 1, 1);
        ped_req = 1'b0;
        expect_ph(0, 1, 2);
        expect_ph(0, 2, 2);
        expect_ph(0, 3, 1);
        expect_ph(0, 6, 1);
        ped_req = 1'b1;
        expect_ph(0, 6, 1);
        ped_req = 1'b0;
        expect_ph(0, 6, 1);
        expect_ph(0, 4, 10);
        expect_ph(0, 5, 2);
        expect_ph(0, 0, 1);
        expect_ph(0, 1, 1);

        // night flashing entered from EW green
        do_reset();
        expect_ph(0, 0, 1);
        expect_ph(0, 1, 10);
        expect_ph(0, 2, 2);
        expect_ph(0, 3, 1);
        flash_en = 1'b1;
        expect_ph(0, 4, 4);
        expect_ph(0, 5, 2);
        expect_ph(0, 0, 1);
        expect_flash(1'b1);
        expect_flash(1'b1);
        expect_flash(1'b0);
        expect_flash(1'b0);
        expect_flash(1'b1);
        expect_flash(1'b1);
        flash_en = 1'b0;
        expect_flash(1'b0);
        expect_ph(0, 0, 1);
        expect_ph(0, 1, 1);

        // async reset mid-yellow with a pending pedestrian request
        do_reset();
        expect_ph(0, 0, 1);
        expect_ph(0, 1, 1);
        ped_req = 1'b1;
        expect_ph(0, 1, 1);
        ped_req = 1'b0;
        expect_ph(0, 1, 2);
        expect_ph(0, 2, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_phase", phase, 0);
        chk("arst_lamps", lamps1, 7'b100_100_0);
        step();
        step();
        rst = 1'b1;
        full_period();

        // short-timer variant: max 15 without demand, 1 with demand
        rst2 = 1'b0;
        step();
        step();
        chk("rst2_lamps", lamps2, 7'b100_100_0);
        rst2 = 1'b1;
        expect_ph(1, 0, 3);
        expect_ph(1, 1, 15);
        expect_ph(1, 2, 1);
        expect_ph(1, 3, 3);
        expect_ph(1, 4, 15);
        expect_ph(1, 5, 1);
        expect_ph(1, 0, 3);
        ew_req = 1'b1;
        expect_ph(1, 1, 1);
        expect_ph(1, 2, 1);
        expect_ph(1, 3, 2);
        ew_req = 1'b0;
        ns_req = 1'b1;
        expect_ph(1, 3, 1);
        expect_ph(1, 4, 1);
        ns_req = 1'b0;
        expect_ph(1, 5, 1);
        expect_ph(1, 0, 3);
        expect_ph(1, 1, 15);
        expect_ph(1, 2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/traffic_intersection.md
Name: traffic_intersection

Overview:
Parametrised two-approach (north-south / east-west) traffic-light controller with all-red clearance, vehicle-demand early termination, pedestrian walk phase and a night flashing mode. It generalises the fixed-timing single-signal light controller by making every phase duration a parameter and by driving two conflicting approaches plus a pedestrian signal. Lights are registered and drive lamp drivers directly.

Parameters:
TIMER_W, 8, width of the phase timer; every duration below must be in 1..2^TIMER_W-1
GREEN_MIN, 4, minimum green cycles before demand may end a green
GREEN_MAX, 10, maximum green cycles; green always ends here
YELLOW_T, 2, yellow cycles
RED_CLR, 1, all-red clearance cycles after each yellow
WALK_T, 3, pedestrian walk cycles (all vehicle lights red)
FLASH_T, 2, half-period of flashing mode in cycles

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset; one clock; reset is asynchronous and active-low
ns_req  input  1  NS vehicle demand (level)
ew_req  input  1  EW vehicle demand (level)
ped_req  input  1  pedestrian button (pulse or level)
flash_en  input  1  night flashing mode request (level)
ns_red, ns_yellow, ns_green  output  1 each  NS lamps
ew_red, ew_yellow, ew_green  output  1 each  EW lamps
walk  output  1  pedestrian walk lamp
phase  output  3  current state encoding (debug)

Behaviour:
- States/encoding: CLR_EW=0, NS_GREEN=1, NS_YELLOW=2, CLR_NS=3, EW_GREEN=4, EW_YELLOW=5, WALK=6, FLASH=7.
- Reset (rst=0, async): state CLR_EW, timer 0, ped_pend 0, flash phase 0; ns_red=ew_red=1, all other lamps 0, walk 0, phase 0. Held while rst=0.
- Timer counts cycles spent in current state from 0; cleared on every state change. A state of duration N occupies exactly N cycles.
- Lamps are registered, computed from next state on the same edge as the state register, so lamps never lag phase.
- Lamp decode: NS_GREEN ns_green+ew_red; NS_YELLOW ns_yellow+ew_red; EW_GREEN ew_green+ns_red; EW_YELLOW ew_yellow+ns_red; CLR_*/WALK both red (walk=1 only in WALK); FLASH: ns_yellow and ew_red both equal flash phase bit, all else 0. No green or yellow is ever on for both approaches at once.
- Green exit (NS_GREEN shown; EW symmetric using ns_req): leave after cycle count reaches GREEN_MAX, or after count >= GREEN_MIN when ew_req | ped_pend | flash_en. Green never shorter than GREEN_MIN. ns_req is informational for NS_GREEN (no extension beyond GREEN_MAX).
- Yellow: YELLOW_T cycles, then NS_YELLOW->CLR_NS, EW_YELLOW->CLR_EW.
- Clearance: RED_CLR cycles, then priority: flash_en -> FLASH; else ped_pend -> WALK; else CLR_NS->EW_GREEN, CLR_EW->NS_GREEN.
- WALK: WALK_T cycles; records which clearance it came from and proceeds to that clearance's green (CLR_NS origin -> EW_GREEN, CLR_EW origin -> NS_GREEN).
- ped_pend: set any cycle ped_req=1 outside WALK; cleared on entry to WALK; ped_req during WALK ignored.
- FLASH: flash phase toggles every FLASH_T cycles, starts at 1 on entry. When flash_en=0: go to CLR_EW (RED_CLR cycles), then NS_GREEN. ped_pend cleared on FLASH exit.
- Simultaneous ped and flash at clearance: flash wins; pending ped is served after flash exit only if re-requested.
- Out-of-range encoding is unreachable; default arm forces CLR_EW.

Test Plan:
- Defaults, all inputs 0, release rst -> CLR_EW 1 cycle, NS_GREEN 10, NS_YELLOW 2, CLR_NS 1, EW_GREEN 10, EW_YELLOW 2, CLR_EW 1; period 26 cycles; never both approaches non-red.
- ew_req=1 held from reset -> NS_GREEN lasts exactly 4 cycles, then yellow 2, clear 1, EW_GREEN 10 (ns_req=0).
- ped_req pulse 1 cycle on NS_GREEN cycle 1 -> green ends after 4, yellow 2, CLR_NS 1, WALK 3 with walk=1 and all red, then EW_GREEN; second pulse during WALK produces no extra WALK.
- flash_en=1 during EW_GREEN cycle 0 -> EW green 4, yellow 2, CLR_EW 1, FLASH: ns_yellow=ew_red toggling 1,1,0,0,...; flash_en=0 -> CLR_EW 1 cycle, NS_GREEN.
- rst asserted asynchronously mid NS_YELLOW -> lamps go to both-red immediately (before next edge), walk 0, ped_pend 0; release -> restart as scenario 1.
- Override TIMER_W=4, GREEN_MIN=1, GREEN_MAX=15, YELLOW_T=1, RED_CLR=3 -> greens 15 with no demand, 1 with demand; clear 3 cycles; no timer wrap.
